// File: rtl/parity_pkg.sv
// Shared types and constants for the frame parity checker.
// Holds FSM state encodings and parity mode constants.
package parity_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

   // Next value of a saturating up-counter.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] val,
      input logic [31:0] max
   );
      return (val == max) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/parity_word.sv
// Combinational XOR-reduce of one data word.
// Ports: data (WIDTH bits) in, parity (1 bit) out.
module parity_word #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = ^data;

endmodule

// File: rtl/parity_stream_checker.sv
// Folds FRAME_LEN handshaked words into a frame parity bit,
// checks it against in_parity and keeps a saturating error count.
// Ports: clk, rst (sync high), mode_odd, in_valid/in_ready/in_data,
// in_parity, word_parity, out_valid, out_parity, out_error, err_count.
module parity_stream_checker
   import parity_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_odd,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_parity,
   output logic             word_parity,
   output logic             out_valid,
   output logic             out_parity,
   output logic             out_error,
   output logic [CNT_W-1:0] err_count
);

   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic             acc_q, acc_d;
   logic             mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             par_in_q, par_in_d;
   logic             wpar_q, wpar_d;
   logic             opar_q, opar_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic wp;
   logic xfer;
   logic fin;
   logic fin_acc;
   logic fin_mode;
   logic fin_err;

   parity_word #(
      .WIDTH (WIDTH)
   ) u_word (
      .data   (in_data),
      .parity (wp)
   );

   // Ready is forced low while reset is asserted so no word can
   // slip in at the reset edge.
   assign in_ready = !rst && (state_q != ST_REPORT);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      fin      = 1'b0;
      fin_acc  = acc_q;
      fin_mode = mode_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               acc_d    = wp;
               mode_d   = mode_odd;
               cnt_d    = CW'(1);
               fin_acc  = wp;
               fin_mode = mode_odd;
               if (FRAME_LEN == 1) begin
                  fin     = 1'b1;
                  state_d = ST_REPORT;
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_ACCUM: begin
            if (xfer) begin
               acc_d   = acc_q ^ wp;
               cnt_d   = CW'(cnt_q + 1'b1);
               fin_acc = acc_q ^ wp;
               if (cnt_q == LAST) begin
                  fin     = 1'b1;
                  state_d = ST_REPORT;
               end
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Results are computed at the last transfer so they land on
   // the same edge that enters REPORT.
   always_comb begin
      wpar_d    = wpar_q;
      opar_d    = opar_q;
      par_in_d  = par_in_q;
      err_cnt_d = err_cnt_q;
      fin_err   = (fin_acc ^ fin_mode) ^ in_parity;
      if (xfer) begin
         wpar_d = wp;
      end
      if (fin) begin
         opar_d   = fin_acc ^ fin_mode;
         par_in_d = in_parity;
         if (fin_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= 1'b0;
         mode_q    <= MODE_EVEN;
         cnt_q     <= '0;
         par_in_q  <= 1'b0;
         wpar_q    <= 1'b0;
         opar_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         par_in_q  <= par_in_d;
         wpar_q    <= wpar_d;
         opar_q    <= opar_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign word_parity = wpar_q;
   assign out_valid   = (state_q == ST_REPORT);
   assign out_parity  = opar_q;
   assign out_error   = opar_q ^ par_in_q;
   assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench for parity_stream_checker.
// Three instances: default, CNT_W=2 and FRAME_LEN=1.
module tb_parity_stream_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode_odd;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_parity;

   logic       in_ready, word_parity, out_valid, out_parity, out_error;
   logic [7:0] err_count;

   logic       s_ready, s_wp, s_valid, s_par, s_err;
   logic [1:0] s_cnt;

   logic       v1, p1;
   logic [3:0] d1;
   logic       r1, wp1, ov1, op1, oe1;
   logic [7:0] ec1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       par;
      logic       err;
      logic [7:0] cm;
      logic [1:0] cs;
   } exp_t;

   exp_t exp_q[$];
   int   cnt_m;
   int   cnt_s;
   bit   run = 0;
   bit   wp_chk = 0;
   logic wp_exp;

   always #5 clk = ~clk;

   parity_stream_checker #(.WIDTH(4), .FRAME_LEN(4), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .mode_odd(mode_odd), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
      .word_parity(word_parity), .out_valid(out_valid),
      .out_parity(out_parity), .out_error(out_error),
      .err_count(err_count)
   );

   parity_stream_checker #(.WIDTH(4), .FRAME_LEN(4), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .mode_odd(mode_odd), .in_valid(in_valid),
      .in_ready(s_ready), .in_data(in_data), .in_parity(in_parity),
      .word_parity(s_wp), .out_valid(s_valid),
      .out_parity(s_par), .out_error(s_err),
      .err_count(s_cnt)
   );

   parity_stream_checker #(.WIDTH(4), .FRAME_LEN(1), .CNT_W(8)) u_one (
      .clk(clk), .rst(rst), .mode_odd(mode_odd), .in_valid(v1),
      .in_ready(r1), .in_data(d1), .in_parity(p1),
      .word_parity(wp1), .out_valid(ov1),
      .out_parity(op1), .out_error(oe1),
      .err_count(ec1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run && !rst && out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_parity", out_parity, e.par);
            chk("out_error", out_error, e.err);
            chk("err_count", err_count, e.cm);
            chk("sat_valid", s_valid, 1);
            chk("sat_err_count", s_cnt, e.cs);
            chk("report_ready", in_ready, 0);
         end
      end
   end

   task automatic wp_check();
      if (wp_chk) begin
         chk("word_parity", word_parity, wp_exp);
         wp_chk = 0;
      end
   endtask

   task automatic send_word(input logic [3:0] d, input logic m,
                            input logic p, output int waits);
      @(negedge clk);
      wp_check();
      in_valid  = 1'b1;
      in_data   = d;
      mode_odd  = m;
      in_parity = p;
      waits     = 0;
      while (!in_ready && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(posedge clk);
      wp_exp = ^d;
      wp_chk = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wp_check();
         in_valid = 1'b0;
         in_data  = 4'h0;
      end
   endtask

   task automatic send_frame(input logic [15:0] w, input logic m,
                             input logic p, input bit gaps,
                             input bit flip, output int first_wait);
      exp_t e;
      int   wt;
      e.par = (^w) ^ m;
      e.err = e.par ^ p;
      if (e.err) begin
         if (cnt_m < 255) cnt_m++;
         if (cnt_s < 3) cnt_s++;
      end
      e.cm = 8'(cnt_m);
      e.cs = 2'(cnt_s);
      first_wait = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) exp_q.push_back(e);
         send_word(w[i*4 +: 4], (i > 0 && flip) ? ~m : m,
                   (i == 3) ? p : ~p, wt);
         if (i == 0) first_wait = wt;
         if (gaps && i < 3) idle(1);
      end
   endtask

   initial begin
      int w;
      int n;
      rst       = 1'b1;
      mode_odd  = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      in_parity = 1'b0;
      v1        = 1'b0;
      d1        = 4'h0;
      p1        = 1'b0;
      cnt_m     = 0;
      cnt_s     = 0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_wp", word_parity, 0);
      chk("rst_par", out_parity, 0);
      chk("rst_err", out_error, 0);
      chk("rst_cnt", err_count, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 1);
      run = 1;

      send_frame(16'hF031, 1'b0, 1'b1, 0, 0, w);
      chk("first_wait", w, 0);
      send_frame(16'hF031, 1'b1, 1'b1, 0, 1, w);
      chk("report_bubble", w, 1);
      send_frame(16'hF031, 1'b0, 1'b1, 1, 0, w);
      chk("held_through_report", w, 1);
      idle(3);

      send_word(4'h5, 1'b0, 1'b0, w);
      send_word(4'h1, 1'b0, 1'b0, w);
      @(negedge clk);
      wp_check();
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      cnt_m = 0;
      cnt_s = 0;
      @(negedge clk);
      chk("midrst_ready", in_ready, 0);
      rst = 1'b0;
      send_frame(16'h0007, 1'b0, 1'b1, 0, 0, w);
      idle(2);

      for (int k = 0; k < 5; k++) begin
         send_frame(16'hF031, 1'b0, 1'b0, 0, 0, w);
      end
      idle(3);
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", exp_q.size(), 0);

      @(negedge clk);
      chk("one_idle_ready", r1, 1);
      v1       = 1'b1;
      d1       = 4'hB;
      p1       = 1'b0;
      mode_odd = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      chk("one_valid", ov1, 1);
      chk("one_ready", r1, 0);
      chk("one_par", op1, 1);
      chk("one_err", oe1, 1);
      chk("one_wp", wp1, 1);
      chk("one_cnt", ec1, 1);
      @(negedge clk);
      chk("one_pulse", ov1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

- Clocked, parametrised successor to the team's combinational four-input XOR parity gate.
- Accepts a stream of WIDTH-bit words with a valid/ready handshake and folds FRAME_LEN words into one frame parity bit (even or odd mode).
- Compares the result against a parity bit supplied with the last word, flags mismatches and keeps a saturating error count.
- Sits between a word source and the lab's status/LED logic as the frame-integrity checker.

## Interface
- WIDTH, 4: data word width in bits, ≥1.
- FRAME_LEN, 4: words per frame, ≥1.
- CNT_W, 8: error counter width.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_odd  in  1  0 = even parity, 1 = odd parity; sampled only when a frame's first word is accepted.
- in_valid  in  1  source has a word on in_data.
- in_ready  out  1  checker can accept; a transfer occurs when in_valid && in_ready at a rising edge.
- in_data  in  WIDTH  data word.
- in_parity  in  1  expected frame parity; sampled only with the frame's last word.
- word_parity  out  1  XOR of the most recently accepted word (registered).
- out_valid  out  1  one-cycle pulse: the frame result is valid.
- out_parity  out  1  computed frame parity; held until the next report.
- out_error  out  1  out_parity != captured in_parity; held until the next report.
- err_count  out  CNT_W  frames in error since reset; saturating.

## Operation
- States:
  - IDLE: in_ready=1, waiting for the first word.
  - ACCUM: in_ready=1, collecting words 2..FRAME_LEN.
  - REPORT: in_ready=0, out_valid=1 for exactly one cycle.
- IDLE → ACCUM on a transfer when FRAME_LEN>1.
- IDLE → REPORT on a transfer when FRAME_LEN=1.
- ACCUM → REPORT on the transfer that brings the word count to FRAME_LEN.
- REPORT → IDLE unconditionally.
- On the first transfer of a frame:
  - acc ← ^in_data.
  - mode latched from mode_odd.
  - word count ← 1.
- On each later transfer: acc ← acc ^ (^in_data); count increments.
- On the last transfer: in_parity is captured.
- Frame parity: out_parity = acc ^ mode_latched, so odd mode inverts.
- out_error = out_parity ^ captured in_parity.
- err_count increments by 1 when REPORT has out_error=1.
- err_count saturates at 2^CNT_W−1 with no wrap.
- word_parity updates on every transfer. It is unchanged otherwise.
- in_valid while in_ready=0 is ignored. The source must hold the word; nothing is buffered.
- mode_odd changes mid-frame have no effect on the current frame.
- Counter width is $clog2(FRAME_LEN+1).

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after reset deasserts. word_parity=0, out_valid=0, out_parity=0, out_error=0, err_count=0. State=IDLE; acc, count and latched mode are cleared.
- Reset mid-frame discards the partial frame. No out_valid is produced for it.
- Result latency: out_valid rises in the cycle after the last transfer.
- Throughput: one word per cycle inside a frame, plus one bubble cycle (REPORT) per frame. Maximum rate is FRAME_LEN words per FRAME_LEN+1 cycles.
- out_parity, out_error and err_count update at the same edge that raises out_valid.
- word_parity is valid one cycle after its transfer.
- rst has priority over every other event at the same edge.

## Structure
- Shared package parity_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_REPORT=2'd2;
  - mode constants MODE_EVEN=1'b0, MODE_ODD=1'b1.
- One natural sub-module: parity_word (parameter WIDTH), a purely combinational XOR-reduce of one word.
  - Instanced once.
  - Reusable as the WIDTH=4 replacement of the four-input XOR gate.
- Top level contains the FSM, accumulator, counters and output registers.

## Test plan
- Reset and even frame, WIDTH=4, FRAME_LEN=4, even mode. Stimulus: reset, then words 4'h1, 4'h3, 4'h0, 4'hF back-to-back, in_parity=1 on the last word. Response: out_valid one cycle after the 4th transfer, out_parity=1, out_error=0, err_count=0.
- Odd mode and error. Stimulus: same words, mode_odd=1, in_parity=1. Response: out_parity=0, out_error=1, err_count=1.
- Handshake stall. Stimulus: in_valid gaps between words, and in_valid held high through REPORT. Response: in_ready=0 only in REPORT, the held word is not counted until accepted, the result matches the gap-free case.
- Reset mid-frame. Stimulus: rst after 2 of 4 words, then a fresh frame 4'h7, 4'h0, 4'h0, 4'h0 in even mode with in_parity=1. Response: exactly one out_valid, out_parity=1, out_error=0.
- Saturation. Stimulus: CNT_W=2, five erroneous frames. Response: err_count reads 1, 2, 3, 3, 3.
- FRAME_LEN=1 boundary. Stimulus: word 4'hB, even mode, in_parity=0. Response: IDLE → REPORT directly, out_parity=1, out_error=1, word_parity=1.
